frame_arbiter: RTL and testbench

- Round-robin scheduler sharing the single framed-transfer bus interface (start/stop/datain/start_read, buff_full/buff_empty) of the buffered device between N requesters.
- Grants one requester at a time and serialises its words into one start…stop frame.
- Applies backpressure from buff_full and caps frame length at the device buffer depth.
- Sits between the requesting sources and the device's bus port.

---
 rtl/frame_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_frame_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_arbiter.sv
// Round-robin arbiter that serialises one requester at a time into start/stop frames.
// Optional auto readout after each frame: define FRAME_ARBITER_AUTO_READ_EN.
module frame_arbiter #(
    parameter int n    = 8,
    parameter int NREQ = 4,
    parameter int size = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*n-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic              start,
    output logic              stop,
    output logic [n-1:0]      datain,
    output logic              start_read,
    input  logic              buff_full,
    input  logic              buff_empty,
    output logic              abort,
    output logic              trunc,
    output logic              busy
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(size + 1);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        READ,
        DRAIN
    } state_t;

`ifdef FRAME_ARBITER_AUTO_READ_EN
    localparam state_t END_ST = READ;
`else
    localparam state_t END_ST = IDLE;
`endif

    state_t            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [LW-1:0]     last_q, last_d;
    logic [CW-1:0]     count_q, count_d;
    logic [n-1:0]      datain_q, datain_d;
    logic              start_q, start_d;
    logic              stop_q, stop_d;
    logic              abort_q, abort_d;
    logic              trunc_q, trunc_d;
    logic [LW-1:0]     pick;
    logic              found;
    logic              fin;

    // Round-robin search upward from the slot after the last grant
    always_comb begin
        pick  = last_q;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!found && req[LW'((int'(last_q) + i) % NREQ)]) begin
                found = 1'b1;
                pick  = LW'((int'(last_q) + i) % NREQ);
            end
        end
    end

    assign fin = req_last[last_q] | (count_q == CW'(size - 1));

    // Next-state, bus word and handshake decode
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        count_d  = count_q;
        datain_d = datain_q;
        start_d  = 1'b0;
        stop_d   = 1'b0;
        abort_d  = 1'b0;
        trunc_d  = 1'b0;
        ack      = '0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    last_d      = pick;
                    state_d     = XFER;
                end
            end
            XFER: begin
                if (!req[last_q]) begin
                    // Requester gave up mid-frame; close it with an empty stop word
                    gnt_d   = '0;
                    count_d = '0;
                    if (count_q != '0) begin
                        stop_d   = 1'b1;
                        datain_d = '0;
                        abort_d  = 1'b1;
                        state_d  = END_ST;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!buff_full) begin
                    ack[last_q] = 1'b1;
                    datain_d    = req_data[last_q*n +: n];
                    start_d     = (count_q == '0);
                    stop_d      = fin;
                    if (fin) begin
                        gnt_d   = '0;
                        count_d = '0;
                        trunc_d = ~req_last[last_q];
                        state_d = END_ST;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
`ifdef FRAME_ARBITER_AUTO_READ_EN
            READ: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                // Ignore buff_empty while the readout pulse is still on the bus
                if (!start_read && buff_empty) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant pointer and registered bus outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            last_q   <= LW'(NREQ - 1);
            count_q  <= '0;
            datain_q <= '0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            abort_q  <= 1'b0;
            trunc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            count_q  <= count_d;
            datain_q <= datain_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            abort_q  <= abort_d;
            trunc_q  <= trunc_d;
        end
    end

`ifdef FRAME_ARBITER_AUTO_READ_EN
    logic rd_q, rd_d;

    assign rd_d = (state_q == READ);

    // One-cycle readout request after each frame end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q <= 1'b0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign start_read = rd_q;
`else
    logic unused_buff_empty;

    assign unused_buff_empty = buff_empty;
    assign start_read        = 1'b0;
`endif

    assign gnt    = gnt_q;
    assign start  = start_q;
    assign stop   = stop_q;
    assign datain = datain_q;
    assign abort  = abort_q;
    assign trunc  = trunc_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_frame_arbiter.sv
// Scoreboard bench for frame_arbiter: per-requester word lists drive the DUT,
// expected bus beats are queued at load time and compared as they appear.
module tb_frame_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int SIZE = 4;

    typedef struct packed {
        logic       acc;
        logic [2:0] id;
        logic       st;
        logic       sp;
        logic       ab;
        logic       tr;
        logic [7:0] data;
    } beat_t;

    logic              clock;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic              start;
    logic              stop;
    logic [N-1:0]      datain;
    logic              start_read;
    logic              buff_full;
    logic              buff_empty;
    logic              abort;
    logic              trunc;
    logic              busy;

    frame_arbiter #(.n(N), .NREQ(NREQ), .size(SIZE)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .req_last   (req_last),
        .gnt        (gnt),
        .ack        (ack),
        .start      (start),
        .stop       (stop),
        .datain     (datain),
        .start_read (start_read),
        .buff_full  (buff_full),
        .buff_empty (buff_empty),
        .abort      (abort),
        .trunc      (trunc),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    logic [7:0] wd [NREQ][64];
    logic       wl [NREQ][64];
    int     wp [NREQ];
    int     rp [NREQ];
    beat_t  expq [$];
    logic   pend = 1'b0;
    logic [2:0] pend_id = '0;
    int     full_lo = 0;
    int     full_hi = 0;
    int     bp_n = 0;
    int     sr_n = 0;
    int     sr_cyc = 0;
    int     stop_cyc = 0;
    int     exp_stops = 0;
    bit     auto_mode = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic load(input int r, input logic [7:0] d, input logic l);
        wd[r][wp[r]] = d;
        wl[r][wp[r]] = l;
        wp[r]++;
    endtask

    task automatic expect_beat(input logic acc, input int id, input logic st,
                               input logic sp, input logic ab, input logic tr,
                               input logic [7:0] d);
        beat_t e;
        e.acc  = acc;
        e.id   = 3'(id);
        e.st   = st;
        e.sp   = sp;
        e.ab   = ab;
        e.tr   = tr;
        e.data = d;
        expq.push_back(e);
        if (sp) exp_stops++;
    endtask

    function automatic bit lists_empty();
        bit e = 1'b1;
        for (int r = 0; r < NREQ; r++) if (rp[r] < wp[r]) e = 1'b0;
        return e;
    endfunction

    task automatic tick();
        beat_t e;
        @(negedge clock);
        cyc++;
        if (pend || start || stop || abort || trunc) begin
            if (expq.size() == 0) begin
                chk("beat_queue", 32'(expq.size()), 32'd1);
            end else begin
                e = expq.pop_front();
                chk("beat", {16'b0, pend, pend_id, start, stop, abort, trunc, datain},
                    {16'b0, e});
            end
        end
        if (start_read) begin
            sr_n++;
            sr_cyc = cyc;
        end
        if (stop) stop_cyc = cyc;
        for (int r = 0; r < NREQ; r++) begin
            if (rp[r] < wp[r]) begin
                req[r]            = 1'b1;
                req_data[r*N +: N] = wd[r][rp[r]];
                req_last[r]       = wl[r][rp[r]];
            end else begin
                req[r]            = 1'b0;
                req_data[r*N +: N] = '0;
                req_last[r]       = 1'b0;
            end
        end
        buff_full  = (cyc >= full_lo) && (cyc < full_hi);
        buff_empty = !auto_mode || ((sr_cyc != 0) && (cyc >= sr_cyc + 5));
        #1;
        pend    = 1'b0;
        pend_id = '0;
        if (buff_full) begin
            bp_n++;
            chk("bp_ack", 32'(ack), 32'd0);
        end
        for (int r = 0; r < NREQ; r++) begin
            if (ack[r]) begin
                pend    = 1'b1;
                pend_id = 3'(r);
                rp[r]++;
            end
        end
    endtask

    task automatic run(input int maxc);
        bit done = 1'b0;
        for (int k = 0; k < maxc && !done; k++) begin
            tick();
            done = (expq.size() == 0) && lists_empty() && !busy;
        end
        chk("run_done", 32'(done), 32'd1);
    endtask

    initial begin
        int c;
        for (int r = 0; r < NREQ; r++) begin
            wp[r] = 0;
            rp[r] = 0;
        end
        reset      = 1'b1;
        req        = '0;
        req_data   = '0;
        req_last   = '0;
        buff_full  = 1'b0;
        buff_empty = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_bus", {27'b0, start, stop, abort, trunc, start_read}, 32'd0);
        chk("rst_data", 32'(datain), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;

        // contention: one-word frames, order 0,1,2,3,0
        load(0, 8'hA0, 1'b1);
        load(0, 8'hA4, 1'b1);
        load(1, 8'hA1, 1'b1);
        load(2, 8'hA2, 1'b1);
        load(3, 8'hA3, 1'b1);
        expect_beat(1, 0, 1, 1, 0, 0, 8'hA0);
        expect_beat(1, 1, 1, 1, 0, 0, 8'hA1);
        expect_beat(1, 2, 1, 1, 0, 0, 8'hA2);
        expect_beat(1, 3, 1, 1, 0, 0, 8'hA3);
        expect_beat(1, 0, 1, 1, 0, 0, 8'hA4);
        run(60);

        // single requester, three words
        load(0, 8'h11, 1'b0);
        load(0, 8'h22, 1'b0);
        load(0, 8'h33, 1'b1);
        expect_beat(1, 0, 1, 0, 0, 0, 8'h11);
        expect_beat(1, 0, 0, 0, 0, 0, 8'h22);
        expect_beat(1, 0, 0, 1, 0, 0, 8'h33);
        tick();
        tick();
        chk("single_gnt", 32'(gnt), 32'h1);
        run(40);
        chk("single_gnt_clr", 32'(gnt), 32'h0);

        // backpressure for four cycles mid-frame
        c = cyc;
        full_lo = c + 4;
        full_hi = c + 8;
        bp_n = 0;
        load(2, 8'h41, 1'b0);
        load(2, 8'h42, 1'b0);
        load(2, 8'h43, 1'b0);
        load(2, 8'h44, 1'b1);
        expect_beat(1, 2, 1, 0, 0, 0, 8'h41);
        expect_beat(1, 2, 0, 0, 0, 0, 8'h42);
        expect_beat(1, 2, 0, 0, 0, 0, 8'h43);
        expect_beat(1, 2, 0, 1, 0, 0, 8'h44);
        run(40);
        chk("bp_cycles", 32'(bp_n), 32'd4);

        // truncation at SIZE words, then requester 1, then leftover aborts
        for (int i = 0; i < 6; i++) load(0, 8'(8'h50 + i), 1'b0);
        load(1, 8'h60, 1'b1);
        expect_beat(1, 0, 1, 0, 0, 0, 8'h50);
        expect_beat(1, 0, 0, 0, 0, 0, 8'h51);
        expect_beat(1, 0, 0, 0, 0, 0, 8'h52);
        expect_beat(1, 0, 0, 1, 0, 1, 8'h53);
        expect_beat(1, 1, 1, 1, 0, 0, 8'h60);
        expect_beat(1, 0, 1, 0, 0, 0, 8'h54);
        expect_beat(1, 0, 0, 0, 0, 0, 8'h55);
        expect_beat(0, 0, 0, 1, 1, 0, 8'h00);
        run(80);

        // requester 2 drops after two words
        load(2, 8'h71, 1'b0);
        load(2, 8'h72, 1'b0);
        expect_beat(1, 2, 1, 0, 0, 0, 8'h71);
        expect_beat(1, 2, 0, 0, 0, 0, 8'h72);
        expect_beat(0, 0, 0, 1, 1, 0, 8'h00);
        run(40);
        chk("abort_busy", 32'(busy), 32'd0);

`ifdef FRAME_ARBITER_AUTO_READ_EN
        auto_mode = 1'b1;
        sr_cyc = 0;
        load(1, 8'h81, 1'b0);
        load(1, 8'h82, 1'b1);
        expect_beat(1, 1, 1, 0, 0, 0, 8'h81);
        expect_beat(1, 1, 0, 1, 0, 0, 8'h82);
        for (int k = 0; k < 40 && sr_cyc == 0; k++) tick();
        chk("rd_lat", 32'(sr_cyc - stop_cyc), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("drain_busy", 32'(busy), 32'd1);
        end
        tick();
        chk("drain_done", 32'(busy), 32'd0);
        load(3, 8'h91, 1'b1);
        expect_beat(1, 3, 1, 1, 0, 0, 8'h91);
        run(40);
        auto_mode = 1'b0;
`endif

        // reset asserted mid-frame clears outputs at once
        load(1, 8'hC1, 1'b0);
        load(1, 8'hC2, 1'b0);
        load(1, 8'hC3, 1'b1);
        expect_beat(1, 1, 1, 0, 0, 0, 8'hC1);
        tick();
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("rstmid_gnt", 32'(gnt), 32'd0);
        chk("rstmid_bus", {28'b0, start, stop, abort, busy}, 32'd0);
        chk("rstmid_data", 32'(datain), 32'd0);
        chk("rstmid_ack", 32'(ack), 32'd0);
        chk("rstmid_q", 32'(expq.size()), 32'd0);
        for (int r = 0; r < NREQ; r++) rp[r] = wp[r];
        pend = 1'b0;
        req  = '0;
        @(negedge clock);
        reset = 1'b0;
        run(10);

`ifdef FRAME_ARBITER_AUTO_READ_EN
        chk("rd_pulses", 32'(sr_n), 32'(exp_stops));
`else
        chk("rd_pulses", 32'(sr_n), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
